// File: rtl/shift_matmul_engine.sv
// Multiplier-free matrix multiply: activations times power-of-two weight codes, accumulated
// per output column group and written back as saturated fixed-point results.
module shift_matmul_engine #(
    parameter int unsigned M_ROWS = 1,
    parameter int unsigned K_DIM  = 4,
    parameter int unsigned N_COLS = 4,
    parameter int unsigned LANES  = 2,
    parameter int unsigned INT_W  = 10,
    parameter int unsigned FRAC_W = 10,
    parameter int unsigned CODE_W = 6,
    parameter int unsigned WT_LAT = 2,
    localparam int unsigned DW    = INT_W + FRAC_W,
    localparam int unsigned WA_W  = (K_DIM * N_COLS / LANES > 1) ?
                                    $clog2(K_DIM * N_COLS / LANES) : 1,
    // One spare bit so out-of-range indices are expressible.
    localparam int unsigned RA_W  = $clog2(M_ROWS * N_COLS) + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [DW-1:0]             in_data,
    output logic                      in_ready,
    input  logic                      relu_en,
    output logic [WA_W-1:0]           wt_addr,
    input  logic [LANES*CODE_W-1:0]   wt_data,
    input  logic                      rd_en,
    input  logic [RA_W-1:0]           rd_addr,
    output logic [DW-1:0]             rd_data,
    output logic                      busy,
    output logic                      done,
    output logic                      ovf
);

    localparam int unsigned GROUPS = N_COLS / LANES;
    localparam int unsigned N_ACT  = M_ROWS * K_DIM;
    localparam int unsigned N_RES  = M_ROWS * N_COLS;
    localparam int unsigned ACC_W  = 2 * DW + $clog2(K_DIM);
    localparam int unsigned I_W    = (M_ROWS > 1) ? $clog2(M_ROWS) : 1;
    localparam int unsigned K_W    = (K_DIM > 1) ? $clog2(K_DIM) : 1;
    localparam int unsigned G_W    = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int unsigned L_W    = (N_ACT > 1) ? $clog2(N_ACT) : 1;
    localparam int unsigned W_W    = (WT_LAT > 1) ? $clog2(WT_LAT) : 1;
    localparam int unsigned R_W    = (N_RES > 1) ? $clog2(N_RES) : 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    if (N_COLS % LANES != 0) begin : g_bad_lanes
        $error("N_COLS must be a multiple of LANES");
    end
    if (CODE_W < 3) begin : g_bad_code
        $error("CODE_W must be at least 3");
    end
    if (WT_LAT < 1) begin : g_bad_lat
        $error("WT_LAT must be at least 1");
    end

    typedef enum logic [2:0] {StLoad, StIssue, StWait, StAcc, StWrite, StDone} state_t;

    state_t                  state;
    logic [I_W-1:0]          i_cnt;
    logic [K_W-1:0]          k_cnt;
    logic [G_W-1:0]          g_cnt;
    logic [L_W-1:0]          load_cnt;
    logic [W_W-1:0]          wait_cnt;
    logic                    relu_q;
    logic signed [DW-1:0]    act_buf [N_ACT];
    logic [DW-1:0]           res_buf [N_RES];
    logic signed [ACC_W-1:0] acc     [LANES];

    logic                    accept;
    logic [L_W-1:0]          a_idx;
    logic signed [ACC_W-1:0] prod    [LANES];
    logic signed [ACC_W-1:0] floor_v [LANES];
    logic signed [ACC_W-1:0] sat_v   [LANES];
    logic [DW-1:0]           res_val [LANES];
    logic [R_W-1:0]          res_idx [LANES];
    logic [LANES-1:0]        sat_hit;

    function automatic logic signed [ACC_W-1:0] product(input logic signed [DW-1:0] a,
                                                        input logic [CODE_W-1:0]    code);
        logic signed [ACC_W-1:0] base;
        logic signed [ACC_W-1:0] p;
        logic [CODE_W-3:0]       s;
        s    = code[CODE_W-3:0];
        base = {{(ACC_W-DW){a[DW-1]}}, a};
        base = base <<< FRAC_W;
        if (!code[CODE_W-2]) begin
            p = base <<< s;
        end else if (&s) begin
            p = '0;
        end else begin
            p = base >>> s;
        end
        if (code[CODE_W-1]) begin
            p = -p;
        end
        return p;
    endfunction

    assign in_ready = (state == StLoad) || (state == StDone);
    assign accept   = in_valid && in_ready;

    always_comb begin
        a_idx   = L_W'(int'(i_cnt) * int'(K_DIM) + int'(k_cnt));
        sat_hit = '0;
        for (int l = 0; l < LANES; l++) begin
            prod[l]    = product(act_buf[a_idx], wt_data[l*CODE_W +: CODE_W]);
            floor_v[l] = acc[l] >>> FRAC_W;
            if (floor_v[l] > SAT_MAX) begin
                sat_v[l]   = SAT_MAX;
                sat_hit[l] = 1'b1;
            end else if (floor_v[l] < SAT_MIN) begin
                sat_v[l]   = SAT_MIN;
                sat_hit[l] = 1'b1;
            end else begin
                sat_v[l] = floor_v[l];
            end
            // ReLU applies after saturation so ovf still reports the clipped magnitude.
            res_val[l] = (relu_q && sat_v[l][ACC_W-1]) ? '0 : sat_v[l][DW-1:0];
            res_idx[l] = R_W'(int'(i_cnt) * int'(N_COLS) + int'(g_cnt) * int'(LANES) + l);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= StLoad;
            i_cnt    <= '0;
            k_cnt    <= '0;
            g_cnt    <= '0;
            load_cnt <= '0;
            wait_cnt <= '0;
            relu_q   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            wt_addr  <= '0;
            for (int l = 0; l < LANES; l++) begin
                acc[l] <= '0;
            end
        end else begin
            unique case (state)
                StLoad: begin
                    if (accept) begin
                        if (load_cnt == L_W'(N_ACT - 1)) begin
                            load_cnt <= '0;
                            relu_q   <= relu_en;
                            busy     <= 1'b1;
                            state    <= StIssue;
                        end else begin
                            load_cnt <= load_cnt + 1'b1;
                        end
                    end
                end
                StIssue: begin
                    wt_addr  <= WA_W'(int'(k_cnt) * int'(GROUPS) + int'(g_cnt));
                    wait_cnt <= '0;
                    state    <= StWait;
                end
                StWait: begin
                    if (wait_cnt == W_W'(WT_LAT - 1)) begin
                        state <= StAcc;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                StAcc: begin
                    // k == 0 restarts the accumulation for a fresh (row, group) pass.
                    for (int l = 0; l < LANES; l++) begin
                        acc[l] <= (k_cnt == '0) ? prod[l] : acc[l] + prod[l];
                    end
                    if (k_cnt == K_W'(K_DIM - 1)) begin
                        k_cnt <= '0;
                        state <= StWrite;
                    end else begin
                        k_cnt <= k_cnt + 1'b1;
                        state <= StIssue;
                    end
                end
                StWrite: begin
                    if (|sat_hit) begin
                        ovf <= 1'b1;
                    end
                    if (g_cnt == G_W'(GROUPS - 1)) begin
                        g_cnt <= '0;
                        if (i_cnt == I_W'(M_ROWS - 1)) begin
                            i_cnt <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= StDone;
                        end else begin
                            i_cnt <= i_cnt + 1'b1;
                            state <= StIssue;
                        end
                    end else begin
                        g_cnt <= g_cnt + 1'b1;
                        state <= StIssue;
                    end
                end
                StDone: begin
                    if (accept) begin
                        done <= 1'b0;
                        ovf  <= 1'b0;
                        if (N_ACT == 1) begin
                            relu_q <= relu_en;
                            busy   <= 1'b1;
                            state  <= StIssue;
                        end else begin
                            load_cnt <= L_W'(1);
                            state    <= StLoad;
                        end
                    end
                end
                default: state <= StLoad;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            act_buf[(state == StDone) ? '0 : load_cnt] <= in_data;
        end
        if (state == StWrite) begin
            for (int l = 0; l < LANES; l++) begin
                res_buf[res_idx[l]] <= res_val[l];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en && done) begin
            rd_data <= (int'(rd_addr) < int'(N_RES)) ? res_buf[R_W'(rd_addr)] : '0;
        end
    end

endmodule
